// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler: assembles 3-byte UART command packets and forwards single-byte responses
module uart_cmd_assembler #(
  parameter int TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rdy,
  output logic        clr_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_err,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  output logic        tx_busy,
  output logic        resp_sent
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] cmd_n;
  logic [15:0] data_n;
  logic cmd_rdy_n, timed_out, tx_done_q, seen_low, done;
  assign clr_rdy = rdy;
  assign timed_out = state != IDLE && !rdy && cnt == TO_LAST;
  assign done = tx_busy && seen_low && tx_done && !tx_done_q;
  // rx packet state and captured fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cmd <= 8'h00;
      data <= 16'h0000;
      cmd_rdy <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cmd <= cmd_n;
      data <= data_n;
      cmd_rdy <= cmd_rdy_n;
      frame_err <= timed_out;
    end
  end
  // next-state: byte capture wins over timeout; a set of cmd_rdy wins over its clear
  always_comb begin
    state_n = state;
    cnt_n = (state == IDLE || rdy || timed_out) ? '0 : cnt + CW'(1);
    cmd_n = cmd;
    data_n = data;
    cmd_rdy_n = cmd_rdy & ~clr_cmd_rdy;
    if (timed_out) state_n = IDLE;
    else if (rdy)
      case (state)
        IDLE: begin
          cmd_n = rx_data;
          cmd_rdy_n = 1'b0;
          state_n = WAIT_HI;
        end
        WAIT_HI: begin
          data_n[15:8] = rx_data;
          state_n = WAIT_LO;
        end
        default: begin
          data_n[7:0] = rx_data;
          cmd_rdy_n = 1'b1;
          state_n = IDLE;
        end
      endcase
  end
  // tx handshake; completion needs a low tx_done seen after launch so a stale high is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data <= 8'h00;
      trmt <= 1'b0;
      tx_busy <= 1'b0;
      resp_sent <= 1'b0;
      tx_done_q <= 1'b1;
      seen_low <= 1'b0;
    end else begin
      tx_done_q <= tx_done;
      trmt <= send_resp && !tx_busy;
      resp_sent <= done;
      if (send_resp && !tx_busy) begin
        tx_data <= resp;
        tx_busy <= 1'b1;
        seen_low <= 1'b0;
      end else begin
        if (done) tx_busy <= 1'b0;
        if (tx_busy && !tx_done) seen_low <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb_uart_cmd_assembler: directed checks of packet assembly, timeout, response path, reset and a serial end-to-end link
module tb_uart_cmd_assembler;
  localparam int B = 8;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0, resp = 0, tx_data;
  logic rdy = 0, clr_cmd_rdy = 0, send_resp = 0, tx_done = 1;
  logic clr_rdy, cmd_rdy, frame_err, trmt, tx_busy, resp_sent;
  logic [7:0] cmd;
  logic [15:0] data;
  logic [7:0] rx2 = 0, cmd2, tx_data2;
  logic rdy2 = 0, clr_rdy2, cmd_rdy2, frame_err2, trmt2, tx_busy2, resp_sent2;
  logic [15:0] data2;
  logic line = 1;
  int n_cmp = 0, n_err = 0, n_ferr2 = 0;

  always #5 clk = ~clk;

  uart_cmd_assembler #(.TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rdy(rdy), .clr_rdy(clr_rdy),
    .cmd(cmd), .data(data), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .frame_err(frame_err), .resp(resp), .send_resp(send_resp), .tx_data(tx_data),
    .trmt(trmt), .tx_done(tx_done), .tx_busy(tx_busy), .resp_sent(resp_sent));

  uart_cmd_assembler dut2 (
    .clk(clk), .rst(rst), .rx_data(rx2), .rdy(rdy2), .clr_rdy(clr_rdy2),
    .cmd(cmd2), .data(data2), .cmd_rdy(cmd_rdy2), .clr_cmd_rdy(1'b0),
    .frame_err(frame_err2), .resp(8'h00), .send_resp(1'b0), .tx_data(tx_data2),
    .trmt(trmt2), .tx_done(1'b1), .tx_busy(tx_busy2), .resp_sent(resp_sent2));

  always @(posedge clk) if (frame_err2) n_ferr2++;

  // serial receiver model standing in for UART_rcv in front of dut2
  initial forever begin
    logic [7:0] sh;
    wait (line == 0);
    repeat (B / 2) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (B) @(posedge clk);
      sh[i] = line;
    end
    repeat (B) @(posedge clk);
    #1 rx2 = sh;
    rdy2 = 1;
    @(posedge clk);
    while (!clr_rdy2) @(posedge clk);
    #1 rdy2 = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rdy = 1;
    #1 chk("clr_rdy_on_rdy", {15'd0, clr_rdy}, 16'd1);
    tick();
    rdy = 0;
  endtask

  task automatic uart_send(input logic [7:0] b);
    line = 0;
    repeat (B) tick();
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (B) tick();
    end
    line = 1;
    repeat (B) tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_clr_rdy", {15'd0, clr_rdy}, 16'd0);
    chk("rst_cmd", {8'd0, cmd}, 16'h0000);
    chk("rst_data", data, 16'h0000);
    chk("rst_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
    chk("rst_frame_err", {15'd0, frame_err}, 16'd0);
    chk("rst_tx_data", {8'd0, tx_data}, 16'h0000);
    chk("rst_trmt", {15'd0, trmt}, 16'd0);
    chk("rst_tx_busy", {15'd0, tx_busy}, 16'd0);
    chk("rst_resp_sent", {15'd0, resp_sent}, 16'd0);
    rst = 0;
    tick();
    // basic packet
    send_byte(8'h02);
    repeat (5) tick();
    chk("basic_no_rdy_mid", {15'd0, cmd_rdy}, 16'd0);
    send_byte(8'hA5);
    repeat (5) tick();
    send_byte(8'h3C);
    chk("basic_cmd", {8'd0, cmd}, 16'h0002);
    chk("basic_data", data, 16'hA53C);
    chk("basic_cmd_rdy", {15'd0, cmd_rdy}, 16'd1);
    clr_cmd_rdy = 1;
    tick();
    clr_cmd_rdy = 0;
    chk("basic_clr", {15'd0, cmd_rdy}, 16'd0);
    // overwrite and set-wins
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    chk("ovw_cmd_rdy_set", {15'd0, cmd_rdy}, 16'd1);
    send_byte(8'h05);
    chk("ovw_cmd_rdy_drop", {15'd0, cmd_rdy}, 16'd0);
    chk("ovw_cmd", {8'd0, cmd}, 16'h0005);
    send_byte(8'hAA);
    clr_cmd_rdy = 1;
    send_byte(8'hBB);
    clr_cmd_rdy = 0;
    chk("set_wins", {15'd0, cmd_rdy}, 16'd1);
    chk("set_wins_data", data, 16'hAABB);
    clr_cmd_rdy = 1;
    tick();
    clr_cmd_rdy = 0;
    // timeout after first byte
    send_byte(8'h07);
    repeat (19) tick();
    chk("to_not_yet", {15'd0, frame_err}, 16'd0);
    tick();
    chk("to_frame_err", {15'd0, frame_err}, 16'd1);
    chk("to_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
    chk("to_cmd_kept", {8'd0, cmd}, 16'h0007);
    chk("to_data_kept", data, 16'hAABB);
    tick();
    chk("to_pulse_end", {15'd0, frame_err}, 16'd0);
    send_byte(8'h01);
    send_byte(8'hFF);
    send_byte(8'h00);
    chk("post_to_cmd", {8'd0, cmd}, 16'h0001);
    chk("post_to_data", data, 16'hFF00);
    chk("post_to_cmd_rdy", {15'd0, cmd_rdy}, 16'd1);
    // byte arriving in the last allowed cycle beats the timeout
    send_byte(8'h08);
    repeat (19) tick();
    send_byte(8'h09);
    chk("edge_no_ferr", {15'd0, frame_err}, 16'd0);
    tick();
    chk("edge_no_ferr2", {15'd0, frame_err}, 16'd0);
    send_byte(8'h0A);
    chk("edge_cmd", {8'd0, cmd}, 16'h0008);
    chk("edge_data", data, 16'h090A);
    chk("edge_cmd_rdy", {15'd0, cmd_rdy}, 16'd1);
    // response path
    resp = 8'hA5;
    send_resp = 1;
    tick();
    send_resp = 0;
    chk("tx_trmt", {15'd0, trmt}, 16'd1);
    chk("tx_data", {8'd0, tx_data}, 16'h00A5);
    chk("tx_busy", {15'd0, tx_busy}, 16'd1);
    resp = 8'h5A;
    send_resp = 1;
    tick();
    send_resp = 0;
    chk("tx_trmt_once", {15'd0, trmt}, 16'd0);
    chk("tx_ignored", {8'd0, tx_data}, 16'h00A5);
    repeat (3) tick();
    chk("tx_stale_high", {15'd0, resp_sent | ~tx_busy}, 16'd0);
    tx_done = 0;
    repeat (3) tick();
    chk("tx_busy_low", {15'd0, tx_busy}, 16'd1);
    tx_done = 1;
    tick();
    chk("tx_resp_sent", {15'd0, resp_sent}, 16'd1);
    chk("tx_busy_clr", {15'd0, tx_busy}, 16'd0);
    tick();
    chk("tx_resp_sent_end", {15'd0, resp_sent}, 16'd0);
    // reset mid-packet and mid-response
    send_byte(8'h44);
    send_byte(8'h55);
    resp = 8'h77;
    send_resp = 1;
    tick();
    send_resp = 0;
    rst = 1;
    #1;
    chk("mid_rst_cmd", {8'd0, cmd}, 16'h0000);
    chk("mid_rst_data", data, 16'h0000);
    chk("mid_rst_busy", {15'd0, tx_busy}, 16'd0);
    chk("mid_rst_tx_data", {8'd0, tx_data}, 16'h0000);
    chk("mid_rst_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
    tick();
    rst = 0;
    tick();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    chk("post_rst_cmd", {8'd0, cmd}, 16'h0011);
    chk("post_rst_data", data, 16'h2233);
    chk("post_rst_cmd_rdy", {15'd0, cmd_rdy}, 16'd1);
    // end-to-end over a serial line into dut2
    n_ferr2 = 0;
    uart_send(8'hE4);
    uart_send(8'h00);
    uart_send(8'hFF);
    for (int i = 0; i < 100 && !cmd_rdy2; i++) tick();
    chk("e2e_cmd_rdy", {15'd0, cmd_rdy2}, 16'd1);
    chk("e2e_cmd", {8'd0, cmd2}, 16'h00E4);
    chk("e2e_data", data2, 16'h00FF);
    chk("e2e_no_ferr", n_ferr2[15:0], 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
